mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/chip8_mem_pkg.sv | 21 ++
 rtl/mem_rr_pick.sv | 21 ++
 rtl/mem_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/chip8_mem_pkg.sv
// Shared types and constants for the CHIP-8 memory arbiter slice.
package chip8_mem_pkg;

  localparam int AW = 12;  // address width
  localparam int DW = 8;   // data width

  // Charset and reset area: writes below this address are rejected.
  localparam logic [AW-1:0] PROT_LIMIT_DEF = 12'h200;

  typedef enum logic {
    ID_CPU = 1'b0,
    ID_DMA = 1'b1
  } req_id_e;

  typedef enum logic [1:0] {
    ARB,
    LOCK_C,
    LOCK_D
  } arb_state_e;

endpackage

// File: rtl/mem_rr_pick.sv
// 2-way round-robin picker. Bit 0 = CPU, bit 1 = DMA. One-hot (or zero) grant.
module mem_rr_pick
  import chip8_mem_pkg::*;
(
  input  logic    [1:0] req_i,
  input  req_id_e       last_i,   // requester granted most recently
  input  logic    [1:0] mask_i,   // requesters eligible this cycle
  output logic    [1:0] gnt_o
);

  logic [1:0] eff;
  assign eff = req_i & mask_i;

  // On contention, favour whichever requester was not granted last.
  always_comb begin
    gnt_o = '0;
    if (eff == 2'b11) gnt_o = (last_i == ID_CPU) ? 2'b10 : 2'b01;
    else              gnt_o = eff;
  end

endmodule

// File: rtl/mem_arbiter.sv
// CPU / DMA arbiter in front of a single-port memory with 1-cycle read latency.
// Supports a bounded lock so a requester can stream bursts, and flags writes
// into the protected low area.
module mem_arbiter
  import chip8_mem_pkg::*;
#(
  parameter int unsigned   MAX_LOCK   = 16,
  parameter logic [AW-1:0] PROT_LIMIT = PROT_LIMIT_DEF
) (
  input  logic          clk,
  input  logic          reset,
  // CPU port
  input  logic          c_req,
  input  logic          c_write,
  input  logic          c_lock,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  // DMA / loader port
  input  logic          d_req,
  input  logic          d_write,
  input  logic          d_lock,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  // memory port A
  output logic          m_en,
  output logic          m_write,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic          prot_err
);

  arb_state_e    state_q, state_d;
  req_id_e       last_q, last_d;   // reset to DMA so CPU wins first contention
  req_id_e       rid_q;
  logic [7:0]    cnt_q, cnt_d;
  logic          rv_q, perr_q;

  logic [1:0]    req_v, mask, gnt_v;
  logic          gnt_any;
  req_id_e       gid;
  logic          g_write, g_lock;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_wdata;
  logic          own_req, own_lock, own_gnt;

  assign req_v = {d_req, c_req};

  // While locked, only the lock owner is eligible.
  always_comb begin
    case (state_q)
      LOCK_C:  mask = 2'b01;
      LOCK_D:  mask = 2'b10;
      default: mask = 2'b11;
    endcase
  end

  mem_rr_pick u_pick (
    .req_i  (req_v),
    .last_i (last_q),
    .mask_i (mask),
    .gnt_o  (gnt_v)
  );

  assign c_gnt   = gnt_v[0];
  assign d_gnt   = gnt_v[1];
  assign gnt_any = |gnt_v;
  assign gid     = gnt_v[1] ? ID_DMA : ID_CPU;

  // Select the granted requester's access fields.
  always_comb begin
    if (gid == ID_DMA) begin
      g_write = d_write; g_lock = d_lock; g_addr = d_addr; g_wdata = d_wdata;
    end else begin
      g_write = c_write; g_lock = c_lock; g_addr = c_addr; g_wdata = c_wdata;
    end
  end

  // Memory bus is held at zero when idle so nothing toggles without a request.
  assign m_en    = gnt_any;
  assign m_write = gnt_any & g_write;
  assign m_addr  = gnt_any ? g_addr  : '0;
  assign m_wdata = gnt_any ? g_wdata : '0;

  // Read data comes straight from the memory; only rvalid says who owns it.
  assign c_rvalid = rv_q & (rid_q == ID_CPU);
  assign d_rvalid = rv_q & (rid_q == ID_DMA);
  assign c_rdata  = m_rdata;
  assign d_rdata  = m_rdata;
  assign prot_err = perr_q;

  assign own_req  = (state_q == LOCK_D) ? d_req    : c_req;
  assign own_lock = (state_q == LOCK_D) ? d_lock   : c_lock;
  assign own_gnt  = (state_q == LOCK_D) ? gnt_v[1] : gnt_v[0];

  // Next state: lock entry, lock counting, voluntary and forced release.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = gnt_any ? gid : last_q;
    case (state_q)
      ARB: begin
        // With MAX_LOCK of 1 the single locked grant is already the last one.
        if (gnt_any && g_lock && MAX_LOCK > 1) begin
          state_d = (gid == ID_CPU) ? LOCK_C : LOCK_D;
          cnt_d   = 8'd1;
        end
      end
      LOCK_C, LOCK_D: begin
        if (own_gnt ? (!own_lock || (32'(cnt_q) + 32'd1 >= MAX_LOCK))
                    : (!own_req && !own_lock)) begin
          state_d = ARB;
          cnt_d   = '0;
        end else if (own_gnt) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ARB;
        cnt_d   = '0;
      end
    endcase
  end

  // Arbitration state, read-return pipeline and protection flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ARB;
      last_q  <= ID_DMA;
      cnt_q   <= '0;
      rv_q    <= 1'b0;
      rid_q   <= ID_CPU;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      rv_q    <= gnt_any & ~g_write;
      rid_q   <= gid;
      perr_q  <= gnt_any & g_write & (g_addr < PROT_LIMIT);
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a MAX_LOCK=16 instance with a memory model
// and a MAX_LOCK=4 instance sharing the same stimulus for lock-length checks.
module tb_mem_arbiter;

  logic        clk, reset;
  logic        c_req, c_write, c_lock, d_req, d_write, d_lock;
  logic [11:0] c_addr, d_addr;
  logic [7:0]  c_wdata, d_wdata;

  logic        c_gnt, c_rvalid, d_gnt, d_rvalid, m_en, m_write, prot_err;
  logic [7:0]  c_rdata, d_rdata, m_wdata, m_rdata;
  logic [11:0] m_addr;

  logic        c_gnt_b, c_rvalid_b, d_gnt_b, d_rvalid_b, m_en_b, m_write_b, prot_err_b;
  logic [7:0]  c_rdata_b, d_rdata_b, m_wdata_b, m_rdata_b;
  logic [11:0] m_addr_b;

  logic [7:0]  mem [4096];

  int checks = 0;
  int fails  = 0;

  assign m_rdata_b = 8'h00;

  mem_arbiter #(.MAX_LOCK(16)) u_dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_write(c_write), .c_lock(c_lock), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_write(d_write), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_en(m_en), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .prot_err(prot_err)
  );

  mem_arbiter #(.MAX_LOCK(4)) u_dut4 (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_write(c_write), .c_lock(c_lock), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt_b), .c_rvalid(c_rvalid_b), .c_rdata(c_rdata_b),
    .d_req(d_req), .d_write(d_write), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt_b), .d_rvalid(d_rvalid_b), .d_rdata(d_rdata_b),
    .m_en(m_en_b), .m_write(m_write_b), .m_addr(m_addr_b), .m_wdata(m_wdata_b), .m_rdata(m_rdata_b),
    .prot_err(prot_err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: registered read, writes below 0x200 are discarded.
  always @(posedge clk) begin
    if (m_en) begin
      m_rdata <= mem[m_addr];
      if (m_write && m_addr >= 12'h200) mem[m_addr] <= m_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    c_req = 0; c_write = 0; c_lock = 0; c_addr = '0; c_wdata = '0;
    d_req = 0; d_write = 0; d_lock = 0; d_addr = '0; d_wdata = '0;
  endtask

  // Returns at a falling edge with reset just released.
  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Lone CPU access starting at a falling edge; checks grant and the next cycle.
  task automatic cpu_acc(input string tag, input logic wr, input logic [11:0] a,
                         input logic [7:0] wd, input logic [7:0] exp_rd, input logic exp_perr);
    c_req = 1; c_write = wr; c_addr = a; c_wdata = wd;
    #1;
    chk({tag, ".c_gnt"},   c_gnt,   1);
    chk({tag, ".d_gnt"},   d_gnt,   0);
    chk({tag, ".m_en"},    m_en,    1);
    chk({tag, ".m_write"}, m_write, wr);
    chk({tag, ".m_addr"},  m_addr,  a);
    if (wr) chk({tag, ".m_wdata"}, m_wdata, wd);
    @(negedge clk);
    c_req = 0; c_write = 0;
    #1;
    chk({tag, ".c_rvalid"}, c_rvalid, !wr);
    if (!wr) chk({tag, ".c_rdata"}, c_rdata, exp_rd);
    chk({tag, ".d_rvalid"}, d_rvalid, 0);
    chk({tag, ".prot_err"}, prot_err, exp_perr);
    @(negedge clk);
  endtask

  initial begin
    int n1, n2, both;
    logic got1, got2;

    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h000] = 8'hF0; mem[12'h001] = 8'h90;   // start of glyph "0"
    mem[12'h050] = 8'h90;                          // protected-area byte
    mem[12'h200] = 8'hA5; mem[12'h201] = 8'h11; mem[12'h202] = 8'h22;

    // Reset state
    reset = 1'b1;
    idle_inputs();
    #1;
    chk("rst.gnt",    {c_gnt, d_gnt}, 0);
    chk("rst.m_en",   {m_en, m_write}, 0);
    chk("rst.rvalid", {c_rvalid, d_rvalid}, 0);
    chk("rst.perr",   prot_err, 0);
    do_reset();

    // First cycle after release: lone CPU read of 0x200
    cpu_acc("rd200", 0, 12'h200, 8'h00, 8'hA5, 0);

    // Idle: nothing moves
    repeat (2) begin
      #1;
      chk("idle.bus", {c_gnt, d_gnt, m_en, m_write, c_rvalid, d_rvalid, prot_err}, 0);
      chk("idle.addr", m_addr, 0);
      @(negedge clk);
    end

    // Protection: font-area write flagged and discarded; boundary 0x1FF/0x200
    cpu_acc("wr050",  1, 12'h050, 8'hFF, 8'h00, 1);
    cpu_acc("rd050",  0, 12'h050, 8'h00, 8'h90, 0);
    cpu_acc("wr1ff",  1, 12'h1FF, 8'h77, 8'h00, 1);
    cpu_acc("wr200",  1, 12'h200, 8'h3C, 8'h00, 0);
    cpu_acc("rd200b", 0, 12'h200, 8'h00, 8'h3C, 0);

    // Round robin from reset: CPU, DMA, CPU, ...
    do_reset();
    c_req = 1; c_addr = 12'h201;
    d_req = 1; d_addr = 12'h202;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("rr.c_gnt", c_gnt, (i % 2) == 0);
      chk("rr.d_gnt", d_gnt, (i % 2) == 1);
      if (i > 0) begin
        chk("rr.c_rvalid", c_rvalid, ((i - 1) % 2) == 0);
        chk("rr.d_rvalid", d_rvalid, ((i - 1) % 2) == 1);
        if (((i - 1) % 2) == 0) chk("rr.c_rdata", c_rdata, 8'h11);
        else                    chk("rr.d_rdata", d_rdata, 8'h22);
      end
      @(negedge clk);
    end
    idle_inputs();
    #1;
    chk("rr.last_d_rvalid", d_rvalid, 1);
    chk("rr.last_d_rdata",  d_rdata,  8'h22);
    @(negedge clk);

    // Lock burst: DMA writes with lock while CPU waits; MAX_LOCK 16 vs 4
    do_reset();
    d_req = 1; d_lock = 1; d_write = 1; d_addr = 12'h300; d_wdata = 8'h00;
    #1;
    chk("lk.first_d_gnt",  d_gnt,   1);
    chk("lk.first_d_gnt4", d_gnt_b, 1);
    n1 = 1; n2 = 1; got1 = 0; got2 = 0; both = 0;
    @(negedge clk);
    d_addr = 12'h301; d_wdata = 8'h01;
    c_req = 1; c_addr = 12'h201;
    for (int k = 0; k < 24; k++) begin
      #1;
      if (c_gnt && d_gnt)     both++;
      if (c_gnt_b && d_gnt_b) both++;
      if (!got1 && c_gnt)   got1 = 1;
      if (!got1 && d_gnt)   n1++;
      if (!got2 && c_gnt_b) got2 = 1;
      if (!got2 && d_gnt_b) n2++;
      @(negedge clk);
      if (d_gnt && !got1) begin
        d_addr  = d_addr + 12'd1;
        d_wdata = d_wdata + 8'd1;
      end
    end
    idle_inputs();
    chk("lk.cpu_seen16", got1, 1);
    chk("lk.dma_cnt16",  n1,   16);
    chk("lk.cpu_seen4",  got2, 1);
    chk("lk.dma_cnt4",   n2,   4);
    chk("lk.both_gnt",   both, 0);
    chk("lk.mem30f",     mem[12'h30F], 8'h0F);
    @(negedge clk);

    // Lock release by dropping req and lock; CPU waits one cycle
    do_reset();
    d_req = 1; d_lock = 1; d_addr = 12'h202;
    #1;
    chk("rel.d_gnt", d_gnt, 1);
    @(negedge clk);
    d_req = 0; d_lock = 0;
    c_req = 1; c_addr = 12'h201;
    #1;
    chk("rel.c_masked", c_gnt,   0);
    chk("rel.d_rvalid", d_rvalid, 1);
    chk("rel.d_rdata",  d_rdata,  8'h22);
    @(negedge clk);
    #1;
    chk("rel.c_gnt", c_gnt, 1);
    @(negedge clk);
    c_req = 0;
    #1;
    chk("rel.c_rvalid", c_rvalid, 1);
    chk("rel.c_rdata",  c_rdata,  8'h11);
    @(negedge clk);

    // Reset between read grant and return cancels the return
    c_req = 1; c_addr = 12'h201;
    #1;
    chk("rstmid.c_gnt", c_gnt, 1);
    #2;
    reset = 1'b1;
    @(negedge clk);
    c_req = 0;
    #1;
    chk("rstmid.rv_in_rst", c_rvalid, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rstmid.rv_rel", c_rvalid, 0);
    @(negedge clk);
    #1;
    chk("rstmid.rv_late", c_rvalid, 0);
    @(negedge clk);
    cpu_acc("rd000", 0, 12'h000, 8'h00, 8'hF0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
